// File: rtl/io_port_arbiter.sv
// io_port_arbiter: round-robin two-master sequencer for the 8-bit strobe-based I/O port bus
module io_port_arbiter #(
    parameter int READ_LAT = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req0,
    input  logic        req1,
    input  logic        we0,
    input  logic        we1,
    input  logic [15:0] addr0,
    input  logic [15:0] addr1,
    input  logic [7:0]  wdata0,
    input  logic [7:0]  wdata1,
    output logic        ack0,
    output logic        ack1,
    output logic        err0,
    output logic        err1,
    output logic [7:0]  rdata,
    output logic [15:0] port_id,
    output logic [7:0]  out_port,
    output logic        write_strobe,
    output logic        read_strobe,
    input  logic [7:0]  in_port
);
    localparam logic [2:0] LAT = 3'(READ_LAT);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t      state, state_nx;
    logic        owner, last, we_r, err_r, gnt, sel_we, grant, cap;
    logic [15:0] addr_r, sel_addr;
    logic [7:0]  wdata_r, rdata_r, sel_wdata;
    logic [2:0]  cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            owner   <= 1'b0;
            last    <= 1'b1;
            we_r    <= 1'b0;
            err_r   <= 1'b0;
            addr_r  <= '0;
            wdata_r <= '0;
            rdata_r <= '0;
            cnt     <= 3'd1;
        end else begin
            state <= state_nx;
            if (grant) begin
                owner   <= gnt;
                last    <= gnt;
                we_r    <= sel_we;
                addr_r  <= sel_addr;
                wdata_r <= sel_wdata;
                err_r   <= sel_addr[15];
                rdata_r <= '0;
            end
            if (cap)
                rdata_r <= in_port;
            cnt <= (state == WAIT) ? cnt + 3'd1 : 3'd1;
        end
    end

    always_comb begin
        gnt          = (req0 && req1) ? ~last : req1;
        grant        = (state == IDLE) && (req0 || req1);
        sel_we       = gnt ? we1 : we0;
        sel_addr     = gnt ? addr1 : addr0;
        sel_wdata    = gnt ? wdata1 : wdata0;
        cap          = (state == ISSUE && !we_r && LAT == 3'd0) || (state == WAIT && cnt == LAT);
        state_nx     = state;
        case (state)
            IDLE:  state_nx = grant ? (sel_addr[15] ? DONE : ISSUE) : IDLE;
            ISSUE: state_nx = (we_r || LAT == 3'd0) ? DONE : WAIT;
            WAIT:  state_nx = (cnt == LAT) ? DONE : WAIT;
            DONE:  state_nx = IDLE;
        endcase
        port_id      = (state == IDLE) ? 16'h0000 : addr_r;
        write_strobe = (state == ISSUE) && we_r;
        read_strobe  = (state == ISSUE) && !we_r;
        out_port     = write_strobe ? wdata_r : 8'h00;
        ack0         = (state == DONE) && !owner;
        ack1         = (state == DONE) && owner;
        err0         = ack0 && err_r;
        err1         = ack1 && err_r;
        rdata        = (state == DONE) ? rdata_r : 8'h00;
    end
endmodule
